// File: rtl/cbus_cmd_master.sv
// cbus_cmd_master
//   Initiator for the BRAM-style control bus (en/addr/din/wen/dout) used by the
//   register spaces. Commands arrive on a valid/ready port. Each accepted command
//   produces exactly one bus strobe in the next cycle. Read data is captured a fixed
//   RD_LAT cycles after its strobe and is returned in command order through a
//   first-word-fall-through response FIFO.
//
// Parameters
//   ADDR_W     control-bus byte address width (passed through unchanged)
//   DATA_W     control-bus data width
//   RD_LAT     cycles from a read strobe to valid bus_dout (1..4)
//   RSP_DEPTH  response FIFO depth, power of two (2..16)
//
// Ports
//   clk, rst             single clock, synchronous active-high reset
//   cmd_valid/ready      command handshake; cmd_write selects write (1) or read (0)
//   cmd_addr/data/be     command address, write data and write byte enables
//   rsp_valid/ready      read-response handshake; rsp_data is the read data
//   bus_en/addr/din/wen  bus strobe and registered access fields
//   bus_dout             bus read data, valid RD_LAT cycles after a read strobe
//   busy                 reads in flight or responses still queued
module cbus_cmd_master #(
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 1,
  parameter int RSP_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_data,
  input  logic [DATA_W/8-1:0] cmd_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                bus_en,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_din,
  output logic [DATA_W/8-1:0] bus_wen,
  input  logic [DATA_W-1:0]   bus_dout,
  output logic                busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Number of set bits in the read-tag shift register.
  function automatic logic [CNT_W-1:0] count_ones(input logic [RD_LAT-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  // Registered state and outputs
  logic                cmd_ready_r;
  logic                bus_en_r;
  logic                rd_issue_r;     // current bus strobe is a read
  logic [ADDR_W-1:0]   bus_addr_r;
  logic [DATA_W-1:0]   bus_din_r;
  logic [BE_W-1:0]     bus_wen_r;
  logic [RD_LAT-1:0]   rd_sr_r;        // tags reads whose data is still on its way
  logic [DATA_W-1:0]   mem_r [RSP_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [CNT_W-1:0]    count_r;
  logic                rsp_valid_r;
  logic [DATA_W-1:0]   rsp_data_r;
  logic                busy_r;

  // Combinational next-state terms
  logic                accept_s;
  logic                rd_accept_s;
  logic                push_s;
  logic                pop_s;
  logic [RD_LAT-1:0]   rd_sr_next_s;
  logic [CNT_W-1:0]    count_after_pop_s;
  logic [CNT_W-1:0]    count_next_s;
  logic [PTR_W-1:0]    rd_ptr_next_s;
  logic [CNT_W-1:0]    sr_ones_s;
  logic [CNT_W-1:0]    occ_next_s;
  logic [CNT_W-1:0]    inflight_next_s;
  logic [DATA_W-1:0]   rsp_data_next_s;

  assign accept_s    = cmd_valid & cmd_ready_r;
  assign rd_accept_s = accept_s & ~cmd_write;
  // The oldest tag marks the cycle in which bus_dout carries that read's data.
  assign push_s      = rd_sr_r[RD_LAT-1];
  assign pop_s       = rsp_valid_r & rsp_ready;

  // Next-state computation for the tag pipe, FIFO occupancy and credit.
  always_comb begin
    rd_sr_next_s    = '0;
    rd_sr_next_s[0] = rd_issue_r;
    for (int i = 1; i < RD_LAT; i++) begin
      rd_sr_next_s[i] = rd_sr_r[i-1];
    end
    count_after_pop_s = count_r - CNT_W'(pop_s);
    count_next_s      = count_after_pop_s + CNT_W'(push_s);
    rd_ptr_next_s     = rd_ptr_r + PTR_W'(pop_s);
    sr_ones_s         = count_ones(rd_sr_next_s);
    // Credits held: queued responses, reads still in the tag pipe, and the
    // command being issued next cycle (a write holds its credit only then).
    occ_next_s        = count_next_s + sr_ones_s + CNT_W'(accept_s);
    inflight_next_s   = sr_ones_s + CNT_W'(rd_accept_s);
    // Fall-through: if the FIFO drains to empty, a word pushed now is the head.
    if (count_after_pop_s == '0) begin
      rsp_data_next_s = bus_dout;
    end else begin
      rsp_data_next_s = mem_r[rd_ptr_next_s];
    end
  end

  // Control, bus and response output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ready_r <= 1'b0;
      bus_en_r    <= 1'b0;
      rd_issue_r  <= 1'b0;
      bus_addr_r  <= '0;
      bus_din_r   <= '0;
      bus_wen_r   <= '0;
      rd_sr_r     <= '0;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= '0;
      busy_r      <= 1'b0;
    end else begin
      cmd_ready_r <= (occ_next_s < CNT_W'(RSP_DEPTH));
      bus_en_r    <= accept_s;
      rd_issue_r  <= rd_accept_s;
      if (accept_s) begin
        bus_addr_r <= cmd_addr;
        bus_din_r  <= cmd_data;
        bus_wen_r  <= cmd_write ? cmd_be : {BE_W{1'b0}};
      end
      rd_sr_r     <= rd_sr_next_s;
      wr_ptr_r    <= wr_ptr_r + PTR_W'(push_s);
      rd_ptr_r    <= rd_ptr_next_s;
      count_r     <= count_next_s;
      rsp_valid_r <= (count_next_s != '0);
      rsp_data_r  <= rsp_data_next_s;
      busy_r      <= (count_next_s != '0) || (inflight_next_s != '0);
    end
  end

  // Response FIFO storage; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      mem_r[wr_ptr_r] <= bus_dout;
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign bus_en    = bus_en_r;
  assign bus_addr  = bus_addr_r;
  assign bus_din   = bus_din_r;
  assign bus_wen   = bus_wen_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_cbus_cmd_master.sv
// tb_cbus_cmd_master
//   Drives random and directed command streams into cbus_cmd_master, emulates the
//   register space on the bus side, and compares every cycle against a
//   transaction-level model: a reference register array plus a queue of expected
//   read responses, each tagged with the earliest cycle it may appear.
module tb_cbus_cmd_master;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int RD_LAT = 3;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic [BE_W-1:0]   cmd_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              bus_en;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_din;
  logic [BE_W-1:0]   bus_wen;
  logic [DATA_W-1:0] bus_dout;
  logic              busy;

  always #5 clk = ~clk;

  cbus_cmd_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .RSP_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_be(cmd_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .bus_en(bus_en), .bus_addr(bus_addr), .bus_din(bus_din), .bus_wen(bus_wen),
    .bus_dout(bus_dout), .busy(busy)
  );

  function automatic logic [31:0] init_word(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {b, ~b, b ^ 8'h5A, 8'hC3};
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] din,
                                              input logic [3:0] be);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) w[8*b +: 8] = din[8*b +: 8];
    end
    return w;
  endfunction

  // Bus-side register space: byte-enabled writes, reads returned RD_LAT cycles later.
  logic [31:0] smem [256];
  logic [31:0] dly [RD_LAT];
  logic        mem_init;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) smem[i] <= init_word(i);
    end else if (bus_en) begin
      smem[bus_addr[9:2]] <= merge_bytes(smem[bus_addr[9:2]], bus_din, bus_wen);
    end
    dly[0] <= bus_en ? smem[bus_addr[9:2]] : $urandom;
    for (int i = 1; i < RD_LAT; i++) dly[i] <= dly[i-1];
  end
  assign bus_dout = dly[RD_LAT-1];

  // Transaction-level reference model
  typedef struct {
    logic        wr;
    logic [7:0]  idx;
    logic [31:0] data;
    logic [3:0]  be;
  } cmd_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rsp_t;

  cmd_t        cmd_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] ref_mem [256];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          vld_pct;
  int          rdy_pct;
  int          wr_pend;
  logic        last_rst;
  logic        exp_en;
  logic [31:0] exp_addr;
  logic [31:0] exp_din;
  logic [31:0] exp_wen;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, update the model at the edge, check outputs.
  task automatic tick();
    cmd_t c;
    rsp_t r;
    logic acc;
    logic pop;
    logic exp_valid;
    logic exp_ready;
    rsp_ready = ($urandom_range(0, 99) < rdy_pct);
    if (cmd_q.size() > 0 && $urandom_range(0, 99) < vld_pct) begin
      c = cmd_q[0];
      cmd_valid = 1'b1;
      cmd_write = c.wr;
      cmd_addr  = {8'h00, c.idx, 2'b00};
      cmd_data  = c.data;
      cmd_be    = c.be;
    end else begin
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom);
      cmd_addr  = 18'($urandom);
      cmd_data  = $urandom;
      cmd_be    = 4'($urandom);
    end
    acc = !rst && cmd_valid && (cmd_ready === 1'b1);
    pop = !rst && (rsp_valid === 1'b1) && rsp_ready;
    r.due = cyc + RD_LAT + 2;
    @(posedge clk);
    cyc++;
    if (rst) begin
      rsp_q.delete();
      exp_en   = 1'b0;
      exp_addr = 32'h0;
      exp_din  = 32'h0;
      exp_wen  = 32'h0;
      wr_pend  = 0;
      last_rst = 1'b1;
    end else begin
      last_rst = 1'b0;
      if (pop && rsp_q.size() > 0) void'(rsp_q.pop_front());
      exp_en  = acc;
      wr_pend = 0;
      if (acc) begin
        c = cmd_q.pop_front();
        exp_addr = {14'h0, 8'h00, c.idx, 2'b00};
        exp_din  = c.data;
        exp_wen  = c.wr ? {28'h0, c.be} : 32'h0;
        if (c.wr) begin
          wr_pend = 1;
          ref_mem[c.idx] = merge_bytes(ref_mem[c.idx], c.data, c.be);
        end else begin
          r.data = ref_mem[c.idx];
          rsp_q.push_back(r);
        end
      end
    end
    @(negedge clk);
    exp_ready = !last_rst && ((rsp_q.size() + wr_pend) < DEPTH);
    exp_valid = (rsp_q.size() > 0) && (rsp_q[0].due <= cyc);
    check_val("bus_en", 32'(bus_en), 32'(exp_en));
    check_val("bus_addr", 32'(bus_addr), exp_addr);
    check_val("bus_din", bus_din, exp_din);
    check_val("bus_wen", 32'(bus_wen), exp_wen);
    check_val("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
    check_val("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
    check_val("busy", 32'(busy), 32'(rsp_q.size() != 0));
    if (exp_valid) check_val("rsp_data", rsp_data, rsp_q[0].data);
    if (last_rst) check_val("rsp_data_rst", rsp_data, 32'h0);
  endtask

  task automatic run_until_idle(input int max_cyc);
    int i;
    i = 0;
    while ((cmd_q.size() > 0 || rsp_q.size() > 0 || exp_en) && i < max_cyc) begin
      tick();
      i++;
    end
    check_val("idle_reached", 32'(i < max_cyc), 32'h1);
    repeat (3) tick();
  endtask

  task automatic push_cmd(input logic wr, input logic [7:0] idx, input logic [31:0] data,
                          input logic [3:0] be);
    cmd_t c;
    c.wr = wr; c.idx = idx; c.data = data; c.be = be;
    cmd_q.push_back(c);
  endtask

  task automatic push_random(input int n);
    for (int i = 0; i < n; i++) begin
      push_cmd(1'($urandom), 8'($urandom_range(0, 15)), $urandom, 4'($urandom));
    end
  endtask

  initial begin
    int k;
    rst = 1'b1; mem_init = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_be = '0;
    rsp_ready = 1'b0;
    exp_en = 1'b0; exp_addr = 32'h0; exp_din = 32'h0; exp_wen = 32'h0;
    wr_pend = 0; last_rst = 1'b1;
    vld_pct = 100; rdy_pct = 100;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

    repeat (3) tick();
    rst = 1'b0; mem_init = 1'b0;
    repeat (2) tick();

    // Single write, then a read of the neighbouring word.
    push_cmd(1'b1, 8'h40, 32'hDEADBEEF, 4'hF);
    run_until_idle(30);
    push_cmd(1'b0, 8'h41, 32'h0, 4'h0);
    run_until_idle(30);
    // Read back the written word.
    push_cmd(1'b0, 8'h40, 32'h0, 4'h0);
    run_until_idle(30);

    // Five back-to-back reads against a stalled response port.
    rdy_pct = 0;
    for (int i = 0; i < 5; i++) push_cmd(1'b0, 8'(i), 32'h0, 4'h0);
    repeat (12) tick();
    rdy_pct = 100;
    run_until_idle(60);

    // Full FIFO, then one pop while a new read is waiting.
    rdy_pct = 0;
    for (int i = 0; i < 4; i++) push_cmd(1'b0, 8'(8 + i), 32'h0, 4'h0);
    repeat (10) tick();
    push_cmd(1'b0, 8'h0C, 32'h0, 4'h0);
    rdy_pct = 100;
    tick();
    rdy_pct = 0;
    repeat (8) tick();
    rdy_pct = 100;
    run_until_idle(60);

    // Continuous mixed traffic with the response port always ready.
    rdy_pct = 100; vld_pct = 100;
    push_random(64);
    run_until_idle(400);

    // Random handshakes on both ports.
    rdy_pct = 60; vld_pct = 70;
    push_random(200);
    run_until_idle(3000);

    // Reset while one response is queued and two reads are in flight.
    rdy_pct = 0; vld_pct = 100;
    for (int i = 0; i < 3; i++) push_cmd(1'b0, 8'(20 + i), 32'h0, 4'h0);
    k = 0;
    while (!(rsp_q.size() == 3 && rsp_q[0].due == cyc) && k < 20) begin
      tick();
      k++;
    end
    check_val("rst_setup", 32'(k < 20), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rdy_pct = 100;
    repeat (20) tick();
    check_val("cmd_q_drained", 32'(cmd_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
